// File: rtl/axil_interface_if.sv
// AXI-lite read channel bundle between the fetch unit and the 32-to-64-bit read adapter.
interface axil_interface_if;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport rd_mst (output araddr, arvalid, rready, input arready, rdata, rvalid);
  modport rd_slv (input araddr, arvalid, rready, output arready, rdata, rvalid);
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: one outstanding AXI-lite read, results queued as {pc, instr}
// for decode; redirects flush the queue and drain any in-flight read.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  axil_interface_if.rd_mst     imem,
  input  logic                 redirect_valid,
  input  logic [63:0]          redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_pc,
  output logic [31:0]          out_instr
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic [1:0]    state;
  logic [63:0]   pc, req_addr;
  logic          kill;
  logic [63:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          issue, push, pop;

  // araddr is driven straight from req_addr so it cannot move while the adapter slices.
  assign imem.arvalid = (state == ST_ADDR);
  assign imem.araddr  = req_addr;
  assign imem.rready  = (state == ST_DATA) || (state == ST_DROP);

  assign issue = (state == ST_IDLE) && (count < CW'(FIFO_DEPTH)) && !redirect_valid;
  assign push  = (state == ST_DATA) && imem.rvalid && !redirect_valid;
  assign pop   = out_valid && out_ready;

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;
  assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      kill     <= 1'b0;
    end else begin
      if (redirect_valid)
        pc <= redirect_pc & ~64'd3;
      else if (push)
        pc <= req_addr + 64'd4;

      case (state)
        ST_IDLE: if (issue) begin
          req_addr <= pc;
          state    <= ST_ADDR;
        end
        // A redirect cannot retract arvalid; remember it and drain the beat once accepted.
        ST_ADDR: if (imem.arready) begin
          state <= (kill || redirect_valid) ? ST_DROP : ST_DATA;
          kill  <= 1'b0;
        end else if (redirect_valid) begin
          kill <= 1'b1;
        end
        ST_DATA: if (imem.rvalid)        state <= ST_IDLE;
                 else if (redirect_valid) state <= ST_DROP;
        ST_DROP: if (imem.rvalid)        state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= req_addr;
      fifo_instr[wr_ptr] <= imem.rdata;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small AXI-lite memory returning data = address.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  axil_interface_if imem ();

  instr_fetch_unit #(.RESET_PC(64'h1000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem(imem),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, stab_err = 0;
  int ar_stall = 0, r_stall = 0, aw_cnt = 0, rw_cnt = 0;
  logic pend = 1'b0, busy = 1'b0;
  logic [63:0] lat = '0, held = '0;
  logic [63:0] iss_q [$];
  logic [63:0] opc_q [$];
  logic [31:0] oin_q [$];

  // memory: arready after ar_stall cycles, rvalid r_stall cycles after the address beat
  always @(posedge clk) begin
    if (rst) begin
      imem.arready <= 1'b0; imem.rvalid <= 1'b0; imem.rdata <= '0;
      pend <= 1'b0; aw_cnt <= 0; rw_cnt <= 0;
    end else begin
      if (imem.arvalid && !imem.arready && !pend) begin
        if (aw_cnt >= ar_stall) imem.arready <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      if (imem.arvalid && imem.arready) begin
        imem.arready <= 1'b0; pend <= 1'b1; lat <= imem.araddr; aw_cnt <= 0; rw_cnt <= 0;
      end
      if (pend && !imem.rvalid) begin
        if (rw_cnt >= r_stall) begin imem.rvalid <= 1'b1; imem.rdata <= lat[31:0]; end
        else rw_cnt <= rw_cnt + 1;
      end
      if (imem.rvalid && imem.rready) begin imem.rvalid <= 1'b0; pend <= 1'b0; end
    end
  end

  always @(posedge clk) begin
    if (!rst && imem.arvalid && imem.arready) iss_q.push_back(imem.araddr);
    if (!rst && out_valid && out_ready) begin opc_q.push_back(out_pc); oin_q.push_back(out_instr); end
  end

  // araddr must hold from ADDR entry through the cycle rvalid is accepted
  always @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else begin
      if (busy && imem.araddr !== held) stab_err <= stab_err + 1;
      if (imem.arvalid && !busy) begin busy <= 1'b1; held <= imem.araddr; end
      if (imem.rvalid && imem.rready) busy <= 1'b0;
    end
  end

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; ar_stall = 0; r_stall = 0;
    repeat (2) @(negedge clk);
    iss_q.delete(); opc_q.delete(); oin_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (imem.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %0h exp 0", imem.arvalid); end
    checks++; if (imem.rready !== 1'b0) begin errors++; $display("FAIL reset_rready got %0h exp 0", imem.rready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
    checks++; if (imem.araddr !== 64'h1000) begin errors++; $display("FAIL reset_araddr got %0h exp 1000", imem.araddr); end
    checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_out_pc got %0h exp 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %0h exp 0", out_instr); end
  endtask

  task automatic test_seq();
    do_reset(); out_ready = 1'b1;
    for (int i = 0; i < 200 && opc_q.size() < 3; i++) @(negedge clk);
    checks++;
    if (opc_q.size() < 3) begin errors++; $display("FAIL seq_count got %0d exp 3", opc_q.size()); end
    else for (int k = 0; k < 3; k++) begin
      checks++; if (opc_q[k] !== 64'h1000 + 64'(4*k)) begin errors++; $display("FAIL seq_pc%0d got %0h exp %0h", k, opc_q[k], 64'h1000 + 64'(4*k)); end
      checks++; if (oin_q[k] !== 32'h1000 + 32'(4*k)) begin errors++; $display("FAIL seq_instr%0d got %0h exp %0h", k, oin_q[k], 32'h1000 + 32'(4*k)); end
    end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL seq_araddr_stable got %0d exp 0", stab_err); end
  endtask

  task automatic test_backpressure();
    do_reset(); out_ready = 1'b0;
    repeat (60) @(negedge clk);
    checks++; if (iss_q.size() != 2) begin errors++; $display("FAIL bp_issued got %0d exp 2", iss_q.size()); end
    if (iss_q.size() >= 2) begin
      checks++; if (iss_q[0] !== 64'h1000) begin errors++; $display("FAIL bp_addr0 got %0h exp 1000", iss_q[0]); end
      checks++; if (iss_q[1] !== 64'h1004) begin errors++; $display("FAIL bp_addr1 got %0h exp 1004", iss_q[1]); end
    end
    checks++; if (imem.arvalid !== 1'b0) begin errors++; $display("FAIL bp_arvalid got %0h exp 0", imem.arvalid); end
    checks++; if (out_pc !== 64'h1000) begin errors++; $display("FAIL bp_head_pc got %0h exp 1000", out_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 100 && iss_q.size() < 3; i++) @(negedge clk);
    checks++;
    if (iss_q.size() < 3) begin errors++; $display("FAIL bp_resume got %0d reads exp 3", iss_q.size()); end
    else if (iss_q[2] !== 64'h1008) begin errors++; $display("FAIL bp_resume_addr got %0h exp 1008", iss_q[2]); end
  endtask

  task automatic test_redirect_data();
    do_reset(); out_ready = 1'b0; r_stall = 3;
    for (int i = 0; i < 100 && iss_q.size() < 2; i++) @(negedge clk);
    checks++; if (imem.rready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rd_setup got rready %0h out_valid %0h exp 1 1", imem.rready, out_valid); end
    redirect_valid = 1'b1; redirect_pc = 64'h2002;
    @(negedge clk); redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_flush got %0h exp 0", out_valid); end
    checks++; if (imem.rready !== 1'b1 || imem.arvalid !== 1'b0) begin errors++; $display("FAIL rd_drop got rready %0h arvalid %0h exp 1 0", imem.rready, imem.arvalid); end
    for (int i = 0; i < 100 && iss_q.size() < 3; i++) @(negedge clk);
    checks++;
    if (iss_q.size() < 3) begin errors++; $display("FAIL rd_next got %0d reads exp 3", iss_q.size()); end
    else if (iss_q[2] !== 64'h2000) begin errors++; $display("FAIL rd_next_addr got %0h exp 2000", iss_q[2]); end
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    checks++; if (out_pc !== 64'h2000 || out_instr !== 32'h2000) begin errors++; $display("FAIL rd_head got %0h/%0h exp 2000/2000", out_pc, out_instr); end
  endtask

  task automatic test_redirect_addr();
    do_reset(); out_ready = 1'b1; ar_stall = 3;
    for (int i = 0; i < 20 && !imem.arvalid; i++) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    @(negedge clk); redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem.arvalid !== 1'b1 || imem.araddr !== 64'h1000) begin errors++; $display("FAIL ra_hold%0d got arvalid %0h araddr %0h exp 1 1000", k, imem.arvalid, imem.araddr); end
      if (k < 2) @(negedge clk);
    end
    for (int i = 0; i < 200 && iss_q.size() < 2; i++) @(negedge clk);
    checks++;
    if (iss_q.size() < 2) begin errors++; $display("FAIL ra_reads got %0d exp 2", iss_q.size()); end
    else if (iss_q[0] !== 64'h1000 || iss_q[1] !== 64'h2000) begin errors++; $display("FAIL ra_addrs got %0h,%0h exp 1000,2000", iss_q[0], iss_q[1]); end
    for (int i = 0; i < 200 && opc_q.size() < 1; i++) @(negedge clk);
    checks++;
    if (opc_q.size() < 1) begin errors++; $display("FAIL ra_out got none exp 2000"); end
    else if (opc_q[0] !== 64'h2000) begin errors++; $display("FAIL ra_out_pc got %0h exp 2000", opc_q[0]); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset(); out_ready = 1'b1; r_stall = 2;
    for (int i = 0; i < 50 && !(imem.rvalid && imem.rready); i++) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    @(negedge clk); redirect_valid = 1'b0;
    checks++; if (imem.rready !== 1'b0 || imem.arvalid !== 1'b0) begin errors++; $display("FAIL rv_idle got rready %0h arvalid %0h exp 0 0", imem.rready, imem.arvalid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rv_dropped got %0h exp 0", out_valid); end
    for (int i = 0; i < 100 && opc_q.size() < 1; i++) @(negedge clk);
    checks++;
    if (iss_q.size() < 2 || opc_q.size() < 1) begin errors++; $display("FAIL rv_next got %0d reads %0d outs exp 2 1", iss_q.size(), opc_q.size()); end
    else if (iss_q[1] !== 64'h3000 || opc_q[0] !== 64'h3000 || oin_q[0] !== 32'h3000) begin
      errors++; $display("FAIL rv_next_addr got %0h/%0h/%0h exp 3000", iss_q[1], opc_q[0], oin_q[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset(); out_ready = 1'b0; r_stall = 4;
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 50 && !imem.rready; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || imem.rready !== 1'b0 || imem.arvalid !== 1'b0) begin
      errors++; $display("FAIL rst_mid got out_valid %0h rready %0h arvalid %0h exp 0 0 0", out_valid, imem.rready, imem.arvalid);
    end
    iss_q.delete();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 50 && iss_q.size() < 1; i++) @(negedge clk);
    checks++;
    if (iss_q.size() < 1) begin errors++; $display("FAIL rst_mid_first got none exp 1000"); end
    else if (iss_q[0] !== 64'h1000) begin errors++; $display("FAIL rst_mid_first got %0h exp 1000", iss_q[0]); end
  endtask

  task automatic test_wrap();
    rst = 1'b1; redirect_valid = 1'b0; ar_stall = 0; r_stall = 0;
    repeat (2) @(negedge clk);
    iss_q.delete(); opc_q.delete(); oin_q.delete();
    rst = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk); redirect_valid = 1'b0;
    for (int i = 0; i < 100 && opc_q.size() < 2; i++) @(negedge clk);
    checks++;
    if (opc_q.size() < 2 || iss_q.size() < 2) begin errors++; $display("FAIL wrap_count got %0d outs exp 2", opc_q.size()); end
    else begin
      checks++; if (iss_q[0] !== 64'hFFFF_FFFF_FFFF_FFFC || iss_q[1] !== 64'h0) begin errors++; $display("FAIL wrap_addr got %0h,%0h exp fffffffffffffffc,0", iss_q[0], iss_q[1]); end
      checks++; if (opc_q[0] !== 64'hFFFF_FFFF_FFFF_FFFC || oin_q[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_out0 got %0h/%0h exp fffffffffffffffc/fffffffc", opc_q[0], oin_q[0]); end
      checks++; if (opc_q[1] !== 64'h0 || oin_q[1] !== 32'h0) begin errors++; $display("FAIL wrap_out1 got %0h/%0h exp 0/0", opc_q[1], oin_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_backpressure();
    test_redirect_data();
    test_redirect_addr();
    test_redirect_rvalid();
    test_reset_mid_read();
    test_wrap();
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL araddr_stable got %0d exp 0", stab_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
